// File: rtl/pr_dma_if.sv
// pr_dma_if: Pr bus link between pr_dma (master) and the arbiter/bridge (slave).
// Carries request/grant plus the word-addressed read/write data path.
interface pr_dma_if;
    localparam int unsigned ADDR_W = 30;
    localparam int unsigned DATA_W = 32;

    logic              bus_req;
    logic              bus_gnt;
    logic [ADDR_W-1:0] PrAddr;
    logic [DATA_W-1:0] PrWD;
    logic              PrWe;
    logic [DATA_W-1:0] PrRD;

    modport master (
        output bus_req, PrAddr, PrWD, PrWe,
        input  bus_gnt, PrRD
    );

    modport slave (
        input  bus_req, PrAddr, PrWD, PrWe,
        output bus_gnt, PrRD
    );
endinterface

// File: rtl/pr_dma.sv
// pr_dma: single-channel word copy engine, alternating one read and one write per word.
// Optional level completion interrupt is built in when PR_DMA_IRQ_EN is defined.
module pr_dma #(
    parameter  int unsigned CNT_W  = 16,
    localparam int unsigned ADDR_W = 30,
    localparam int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [CNT_W-1:0]  count,
    input  logic              irq_ack,
    output logic              busy,
    output logic              done,
    output logic              irq,
    pr_dma_if.master          pr
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_FIN  = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   src_q, src_d;
    logic [ADDR_W-1:0]   dst_q, dst_d;
    logic [CNT_W-1:0]    rem_q, rem_d;
    logic [DATA_W-1:0]   buf_q, buf_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                req_q, req_d;
    logic                irq_q, irq_d;

    logic                drive_c;
    logic [ADDR_W-1:0]   pr_addr_c;
    logic [DATA_W-1:0]   pr_wd_c;
    logic                pr_we_c;

    // Bus is driven only in the granted cycle itself; a reset cycle never reaches the bus.
    always_comb begin : bus_drive
        drive_c   = pr.bus_gnt && !reset && ((state_q == S_RD) || (state_q == S_WR));
        pr_addr_c = '0;
        pr_wd_c   = '0;
        pr_we_c   = 1'b0;
        if (drive_c) begin
            if (state_q == S_RD) begin
                pr_addr_c = src_q;
            end else begin
                pr_addr_c = dst_q;
                pr_wd_c   = buf_q;
                pr_we_c   = 1'b1;
            end
        end
    end

    always_comb begin : next_state
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        rem_d   = rem_q;
        buf_d   = buf_q;
        irq_d   = irq_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (count != '0) begin
                        src_d   = src_addr;
                        dst_d   = dst_addr;
                        rem_d   = count;
                        state_d = S_RD;
                    end else begin
                        state_d = S_FIN;
                    end
                end
            end
            S_RD: begin
                if (pr.bus_gnt) begin
                    buf_d   = pr.PrRD;
                    state_d = S_WR;
                end
            end
            S_WR: begin
                if (pr.bus_gnt) begin
                    src_d   = src_q + ADDR_W'(1);
                    dst_d   = dst_q + ADDR_W'(1);
                    rem_d   = rem_q - CNT_W'(1);
                    state_d = (rem_q == CNT_W'(1)) ? S_FIN : S_RD;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Status flags are registered copies of the state being entered.
        req_d  = (state_d == S_RD) || (state_d == S_WR);
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_FIN);

`ifdef PR_DMA_IRQ_EN
        // Acknowledge beats a same-cycle completion; a fresh start clears a stale flag.
        if (irq_ack) begin
            irq_d = 1'b0;
        end else if (state_d == S_FIN) begin
            irq_d = 1'b1;
        end else if ((state_q == S_IDLE) && start) begin
            irq_d = 1'b0;
        end
`else
        irq_d = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin : regs
        if (reset) begin
            state_q <= S_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            rem_q   <= '0;
            buf_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            req_q   <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            rem_q   <= rem_d;
            buf_q   <= buf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            req_q   <= req_d;
            irq_q   <= irq_d;
        end
    end

`ifndef PR_DMA_IRQ_EN
    logic unused_irq_ack;
    assign unused_irq_ack = irq_ack;
`endif

    assign busy       = busy_q;
    assign done       = done_q;
    assign irq        = irq_q;
    assign pr.bus_req = req_q;
    assign pr.PrAddr  = pr_addr_c;
    assign pr.PrWD    = pr_wd_c;
    assign pr.PrWe    = pr_we_c;

endmodule

// File: tb/tb_pr_dma.sv
// tb_pr_dma: table-driven and randomized checks of pr_dma against a transfer-level model.
// Expectations for irq follow PR_DMA_IRQ_EN when the bench is built with it.
module tb_pr_dma;
    localparam int unsigned CNT_W = 16;
`ifdef PR_DMA_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif

    logic             clk;
    logic             reset;
    logic             start;
    logic [29:0]      src_addr;
    logic [29:0]      dst_addr;
    logic [CNT_W-1:0] count;
    logic             irq_ack;
    logic             busy;
    logic             done;
    logic             irq;

    pr_dma_if prif();

    pr_dma #(.CNT_W(CNT_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .src_addr (src_addr),
        .dst_addr (dst_addr),
        .count    (count),
        .irq_ack  (irq_ack),
        .busy     (busy),
        .done     (done),
        .irq      (irq),
        .pr       (prif.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_fail;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Source memory: three pinned words at ovr_base, a salted address hash elsewhere.
    logic [31:0] ovr_tab [0:3];
    logic [29:0] ovr_base;
    logic        ovr_en;
    logic [31:0] salt;
    logic [29:0] rd_off;

    assign rd_off     = prif.PrAddr - ovr_base;
    assign prif.PrRD  = (ovr_en && (rd_off < 30'd3)) ? ovr_tab[rd_off[1:0]]
                                                     : ({prif.PrAddr, 2'b01} ^ salt);

    function automatic logic [31:0] model_word(input logic [29:0] a);
        logic [29:0] off;
        off = a - ovr_base;
        if (ovr_en && (off < 30'd3)) return ovr_tab[off[1:0]];
        return {a, 2'b01} ^ salt;
    endfunction

    typedef struct {
        logic        we;
        logic [29:0] addr;
        logic [31:0] data;
    } ev_t;
    ev_t ev_q[$];

    // Bus observer: log every granted cycle, and demand a silent bus otherwise.
    always @(negedge clk) begin
        if (!reset) begin
            if (prif.bus_req && prif.bus_gnt) begin
                ev_q.push_back('{we: prif.PrWe, addr: prif.PrAddr, data: prif.PrWD});
            end else begin
                check("bus_idle", 64'({prif.PrWe, prif.PrAddr, prif.PrWD}), 64'd0);
            end
        end
    end

    task automatic run_xfer(input string name, input logic [29:0] src, input logic [29:0] dst,
                            input int unsigned cnt, input int stall_from, input int stall_len,
                            input bit rand_gnt, input int poke_k, input int exp_tab);
        int unsigned g;
        int          done_k;
        bit          cur_gnt;
        bit          exp_done;
        bit          finished;
        logic [29:0] a;
        g        = 0;
        done_k   = -1;
        finished = 1'b0;
        exp_done = 1'b0;
        ev_q.delete();
        start         = 1'b1;
        src_addr      = src;
        dst_addr      = dst;
        count         = CNT_W'(cnt);
        cur_gnt       = 1'b1;
        prif.bus_gnt  = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        src_addr = 30'($urandom);
        dst_addr = 30'($urandom);
        count    = CNT_W'($urandom);
        for (int k = 0; k <= 400; k++) begin
            if (k > 0 && cur_gnt) g++;
            exp_done = (cnt == 0) ? (k == 0) : (k > 0 && cur_gnt && g == 2 * cnt);
            check({name, "_done"}, 64'(done), 64'(exp_done));
            check({name, "_busy"}, 64'(busy), 64'd1);
            check({name, "_req"}, 64'(prif.bus_req), 64'((cnt != 0) && !exp_done));
            if (done || exp_done) begin
                done_k   = done ? k : -2;
                finished = 1'b1;
                break;
            end
            start = 1'b0;
            if (k == poke_k) begin
                start    = 1'b1;
                src_addr = 30'($urandom);
                dst_addr = 30'($urandom);
                count    = CNT_W'($urandom_range(1, 9));
            end
            cur_gnt = rand_gnt ? ($urandom_range(0, 3) != 0)
                               : !(stall_len > 0 && (k + 1) >= stall_from
                                   && (k + 1) < stall_from + stall_len);
            prif.bus_gnt = cur_gnt;
            @(posedge clk); #1;
        end
        check({name, "_timeout"}, 64'(finished), 64'd1);
        if (exp_tab >= 0) check({name, "_done_cycle"}, 64'(done_k), 64'(exp_tab));
        check({name, "_irq_set"}, 64'(irq), 64'(IRQ_ON));

        start        = 1'b0;
        prif.bus_gnt = 1'b1;
        @(posedge clk); #1;
        check({name, "_done_pulse"}, 64'(done), 64'd0);
        check({name, "_idle_busy"}, 64'(busy), 64'd0);
        check({name, "_idle_req"}, 64'(prif.bus_req), 64'd0);
        check({name, "_irq_hold"}, 64'(irq), 64'(IRQ_ON));
        irq_ack = 1'b1;
        @(posedge clk); #1;
        irq_ack = 1'b0;
        check({name, "_irq_ack"}, 64'(irq), 64'd0);

        check({name, "_nev"}, 64'(ev_q.size()), 64'(2 * cnt));
        for (int i = 0; i < ev_q.size() && i < int'(2 * cnt); i++) begin
            a = src + 30'(i / 2);
            if (i % 2 == 0) begin
                check({name, "_rd"}, 64'({ev_q[i].we, ev_q[i].addr}), 64'({1'b0, a}));
            end else begin
                check({name, "_wr"}, 64'({ev_q[i].we, ev_q[i].addr, ev_q[i].data}),
                      64'({1'b1, dst + 30'(i / 2), model_word(a)}));
            end
        end
    endtask

    typedef struct {
        string       name;
        logic [29:0] src;
        logic [29:0] dst;
        int unsigned cnt;
        int          stall_from;
        int          stall_len;
        int          poke_k;
        bit          ovr;
        int          exp_done;
    } vec_t;
    vec_t vecs [0:6];

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        reset        = 1'b1;
        start        = 1'b0;
        src_addr     = '0;
        dst_addr     = '0;
        count        = '0;
        irq_ack      = 1'b0;
        prif.bus_gnt = 1'b0;
        ovr_tab[0]   = 32'h0000_000A;
        ovr_tab[1]   = 32'h0000_000B;
        ovr_tab[2]   = 32'h0000_000C;
        ovr_tab[3]   = 32'h0000_0000;
        ovr_base     = 30'h0000_1FC0;
        ovr_en       = 1'b0;
        salt         = 32'h1357_9BDF;

        vecs[0] = '{"basic3",  30'h0000_1FC0, 30'h0000_1FC4, 3, 0, 0, -1, 1'b1, 6};
        vecs[1] = '{"zero",    30'h0000_0100, 30'h0000_0200, 0, 0, 0, -1, 1'b0, 0};
        vecs[2] = '{"stall",   30'h0000_2000, 30'h0000_3000, 2, 2, 3, -1, 1'b0, 7};
        vecs[3] = '{"srcwrap", 30'h3FFF_FFFF, 30'h0000_0010, 2, 0, 0, -1, 1'b0, 4};
        vecs[4] = '{"dstwrap", 30'h0000_0055, 30'h3FFF_FFFE, 3, 0, 0, -1, 1'b0, 6};
        vecs[5] = '{"restart", 30'h0000_0400, 30'h0000_0800, 2, 0, 0, 1,  1'b0, 4};
        vecs[6] = '{"single",  30'h0000_0777, 30'h0000_0999, 1, 0, 0, -1, 1'b0, 2};

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_irq", 64'(irq), 64'd0);
        check("rst_req", 64'(prif.bus_req), 64'd0);
        check("rst_bus", 64'({prif.PrWe, prif.PrAddr, prif.PrWD}), 64'd0);

        // Reset wins over a simultaneous start with grant.
        start        = 1'b1;
        src_addr     = 30'h0000_0040;
        dst_addr     = 30'h0000_0080;
        count        = CNT_W'(2);
        prif.bus_gnt = 1'b1;
        @(posedge clk); #1;
        check("rst_prio_busy", 64'(busy), 64'd0);
        check("rst_prio_req", 64'(prif.bus_req), 64'd0);
        start = 1'b0;
        reset = 1'b0;
        @(posedge clk); #1;
        check("post_rst_busy", 64'(busy), 64'd0);

        for (int i = 0; i < 7; i++) begin
            ovr_en = vecs[i].ovr;
            salt   = 32'h2468_ACE1 ^ 32'(i);
            run_xfer(vecs[i].name, vecs[i].src, vecs[i].dst, vecs[i].cnt, vecs[i].stall_from,
                     vecs[i].stall_len, 1'b0, vecs[i].poke_k, vecs[i].exp_done);
        end
        ovr_en = 1'b0;

        // Abort in the middle of a 4-word copy, then a normal single-word copy.
        ev_q.delete();
        start        = 1'b1;
        src_addr     = 30'h0000_0100;
        dst_addr     = 30'h0000_0200;
        count        = CNT_W'(4);
        prif.bus_gnt = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_irq", 64'(irq), 64'd0);
        check("abort_req", 64'(prif.bus_req), 64'd0);
        check("abort_bus", 64'({prif.PrWe, prif.PrAddr, prif.PrWD}), 64'd0);
        ev_q.delete();
        repeat (6) begin
            @(posedge clk); #1;
            check("abort_no_done", 64'(done), 64'd0);
            check("abort_stay_idle", 64'(busy), 64'd0);
        end
        check("abort_no_bus", 64'(ev_q.size()), 64'd0);
        run_xfer("after_abort", 30'h0000_0300, 30'h0000_0400, 1, 0, 0, 1'b0, -1, 2);

        for (int r = 0; r < 24; r++) begin
            logic [29:0] s;
            logic [29:0] d;
            int unsigned n;
            s = 30'($urandom);
            if (r % 4 == 0) s = 30'h3FFF_FFFF - 30'($urandom_range(0, 3));
            d    = 30'($urandom);
            n    = $urandom_range(0, 6);
            salt = $urandom;
            run_xfer("rand", s, d, n, 0, 0, 1'b1, -1, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d",
                 n_checks, n_fail);
        $fatal(1);
    end

endmodule
